// File: rtl/player_collider.sv
// Collision detector for the player box: per frame tick it scans the wall table and
// publishes a left/right/top/bottom contact mask for the player block.
module player_collider #(
    parameter int unsigned N_WALLS  = 8,
    parameter int unsigned PLAYER_W = 32,
    parameter int unsigned PLAYER_H = 32,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic        sim_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] playerPos,
    output logic [7:0]  wall_addr,
    input  logic [39:0] wall_data,
    output logic [3:0]  playerCol,
    output logic        col_valid,
    output logic        busy
);

    localparam logic [7:0]  LAST_IDX = 8'(N_WALLS - 1);
    localparam logic [10:0] PW11     = 11'(PLAYER_W);
    localparam logic [10:0] PH11     = 11'(PLAYER_H);
    localparam logic [10:0] SW11     = 11'(SCREEN_W);
    localparam logic [10:0] SH11     = 11'(SCREEN_H);

    typedef enum logic [1:0] {StIdle, StPrime, StScan, StDone} state_e;

    state_e      r_state;
    logic [9:0]  r_xs;
    logic [9:0]  r_ys;
    logic [3:0]  r_acc;
    logic [7:0]  r_idx;
    logic [7:0]  r_wall_addr;
    logic [3:0]  r_player_col;
    logic        r_col_valid;
    logic        r_busy;

    // Screen-edge preload, computed from the live position at the accepting edge
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [3:0]  w_edge;

    assign w_px   = {1'b0, playerPos[19:10]};
    assign w_py   = {1'b0, playerPos[9:0]};
    assign w_edge = {(w_px == 11'd0), ((w_px + PW11) >= SW11),
                     (w_py == 11'd0), ((w_py + PH11) >= SH11)};

    logic [10:0] w_xs, w_ys;
    logic [10:0] w_x0, w_y0, w_x1, w_y1;
    logic [10:0] w_rcol, w_lcol, w_brow, w_trow, w_xlast, w_ylast;
    logic        w_en, w_vov, w_hov;
    logic [3:0]  w_hits;

    assign w_xs    = {1'b0, r_xs};
    assign w_ys    = {1'b0, r_ys};
    assign w_x0    = {1'b0, wall_data[39:30]};
    assign w_y0    = {1'b0, wall_data[29:20]};
    assign w_x1    = {1'b0, wall_data[19:10]};
    assign w_y1    = {1'b0, wall_data[9:0]};
    assign w_rcol  = w_xs + PW11;
    assign w_lcol  = w_xs - 11'd1;
    assign w_brow  = w_ys + PH11;
    assign w_trow  = w_ys - 11'd1;
    assign w_xlast = w_xs + PW11 - 11'd1;
    assign w_ylast = w_ys + PH11 - 11'd1;

    assign w_en  = (w_x0 <= w_x1) && (w_y0 <= w_y1);
    assign w_vov = (w_y0 <= w_ylast) && (w_ys <= w_y1);
    assign w_hov = (w_x0 <= w_xlast) && (w_xs <= w_x1);

    // Probes at coordinate -1 are skipped; the edge bits already cover them
    assign w_hits[3] = w_en && w_vov && (w_xs != 11'd0) && (w_x0 <= w_lcol) && (w_lcol <= w_x1);
    assign w_hits[2] = w_en && w_vov && (w_x0 <= w_rcol) && (w_rcol <= w_x1);
    assign w_hits[1] = w_en && w_hov && (w_ys != 11'd0) && (w_y0 <= w_trow) && (w_trow <= w_y1);
    assign w_hits[0] = w_en && w_hov && (w_y0 <= w_brow) && (w_brow <= w_y1);

    always_ff @(posedge sim_clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_xs         <= 10'd0;
            r_ys         <= 10'd0;
            r_acc        <= 4'd0;
            r_idx        <= 8'd0;
            r_wall_addr  <= 8'd0;
            r_player_col <= 4'd0;
            r_col_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_col_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_xs        <= playerPos[19:10];
                        r_ys        <= playerPos[9:0];
                        r_acc       <= w_edge;
                        r_idx       <= 8'd0;
                        r_wall_addr <= 8'd0;
                        r_busy      <= 1'b1;
                        r_state     <= StPrime;
                    end
                end
                StPrime: begin
                    r_wall_addr <= (LAST_IDX == 8'd0) ? 8'd0 : 8'd1;
                    r_state     <= StScan;
                end
                StScan: begin
                    r_acc <= r_acc | w_hits;
                    if (r_wall_addr != LAST_IDX) begin
                        r_wall_addr <= r_wall_addr + 8'd1;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= StDone;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                StDone: begin
                    r_player_col <= r_acc;
                    r_col_valid  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign wall_addr = r_wall_addr;
    assign playerCol = r_player_col;
    assign col_valid = r_col_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_player_collider.sv
// Bench for player_collider: directed wall tables, multi-cycle corner cases and randomized
// scans checked against a pixel-walking reference model.
module tb_player_collider;

    localparam int PW = 32;
    localparam int PH = 32;
    localparam int SW = 640;
    localparam int SH = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] playerPos = 20'd0;
    logic [7:0]  wall_addr;
    logic [39:0] wall_data = 40'd0;
    logic [3:0]  playerCol;
    logic        col_valid;
    logic        busy;

    logic [39:0] rom [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Synchronous wall table
    always_ff @(posedge clk) wall_data <= rom[wall_addr[2:0]];

    player_collider #(
        .N_WALLS (8),
        .PLAYER_W(PW),
        .PLAYER_H(PH),
        .SCREEN_W(SW),
        .SCREEN_H(SH)
    ) dut (
        .sim_clk  (clk),
        .rst      (rst),
        .start    (start),
        .playerPos(playerPos),
        .wall_addr(wall_addr),
        .wall_data(wall_data),
        .playerCol(playerCol),
        .col_valid(col_valid),
        .busy     (busy)
    );

    typedef struct {
        logic [19:0]      pos;
        logic [7:0][39:0] w;
        logic [3:0]       exp;
        bit               disturb;
    } vec_t;

    function automatic logic [39:0] wl(int x0, int y0, int x1, int y1);
        return {10'(x0), 10'(y0), 10'(x1), 10'(y1)};
    endfunction

    function automatic logic [19:0] pp(int x, int y);
        return {10'(x), 10'(y)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic bit inside_rect(int c, int r, int x0, int y0, int x1, int y1);
        return (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1);
    endfunction

    // Reference: walk every pixel of each one-pixel probe strip and test it against each wall
    function automatic logic [3:0] model(int xs, int ys, logic [7:0][39:0] w);
        logic [3:0] res;
        res = {xs == 0, xs + PW >= SW, ys == 0, ys + PH >= SH};
        for (int k = 0; k < 8; k++) begin
            int x0, y0, x1, y1;
            x0 = int'(w[k][39:30]);
            y0 = int'(w[k][29:20]);
            x1 = int'(w[k][19:10]);
            y1 = int'(w[k][9:0]);
            if (x0 > x1 || y0 > y1) continue;
            for (int i = 0; i < PH; i++) begin
                if (xs > 0 && inside_rect(xs - 1, ys + i, x0, y0, x1, y1)) res[3] = 1'b1;
                if (inside_rect(xs + PW, ys + i, x0, y0, x1, y1)) res[2] = 1'b1;
            end
            for (int j = 0; j < PW; j++) begin
                if (ys > 0 && inside_rect(xs + j, ys - 1, x0, y0, x1, y1)) res[1] = 1'b1;
                if (inside_rect(xs + j, ys + PH, x0, y0, x1, y1)) res[0] = 1'b1;
            end
        end
        return res;
    endfunction

    task automatic load(input logic [7:0][39:0] w);
        for (int k = 0; k < 8; k++) rom[k] = w[k];
    endtask

    // One scan: pulse start, watch 14 cycles. With disturb, start is re-pulsed so that it is
    // sampled mid-scan and in the DONE cycle, and playerPos is moved to {0,0}.
    task automatic scan(input string name, input logic [19:0] pos, input logic [3:0] exp,
                        input bit disturb);
        int first;
        int cnt;
        first = -1;
        cnt   = 0;
        @(negedge clk);
        start     = 1'b1;
        playerPos = pos;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if (col_valid) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 1) check({name, " busy"}, 32'(busy), 32'd1);
            if (disturb && (k == 2 || k == 9)) begin
                start     = 1'b1;
                playerPos = 20'd0;
            end
        end
        check({name, " latency"}, 32'(first), 32'd10);
        check({name, " pulses"}, 32'(cnt), 32'd1);
        check({name, " playerCol"}, 32'(playerCol), 32'(exp));
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs [6];
    logic [39:0] dis;

    initial begin
        dis = wl(1, 0, 0, 0);
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 8; k++) vecs[v].w[k] = dis;
            vecs[v].disturb = 1'b0;
        end
        vecs[0].pos = pp(200, 300); vecs[0].w[0] = wl(0, 332, 639, 339); vecs[0].exp = 4'b0001;
        vecs[1].pos = pp(200, 300);
        vecs[1].w[0] = wl(232, 0, 240, 479); vecs[1].w[1] = wl(0, 0, 199, 479);
        vecs[1].w[2] = wl(0, 0, 639, 299);   vecs[1].w[3] = wl(0, 332, 639, 339);
        vecs[1].exp = 4'b1111;
        vecs[2].pos = pp(0, 0);     vecs[2].exp = 4'b1010;
        vecs[3].pos = pp(608, 448); vecs[3].exp = 4'b0101;
        vecs[4].pos = pp(200, 300); vecs[4].w[3] = wl(0, 332, 639, 339);
        vecs[4].exp = 4'b0001;      vecs[4].disturb = 1'b1;
        vecs[5].pos = pp(200, 300); vecs[5].w[5] = wl(232, 332, 240, 340); vecs[5].exp = 4'b0000;

        for (int k = 0; k < 8; k++) rom[k] = dis;

        #2;
        check("reset playerCol", 32'(playerCol), 32'd0);
        check("reset col_valid", 32'(col_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wall_addr", 32'(wall_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].w);
            scan($sformatf("vec%0d", v), vecs[v].pos, vecs[v].exp, vecs[v].disturb);
        end

        // Asynchronous reset in the middle of a scan
        load(vecs[1].w);
        scan("pre-reset", vecs[1].pos, 4'b1111, 1'b0);
        @(negedge clk);
        start     = 1'b1;
        playerPos = vecs[1].pos;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst playerCol", 32'(playerCol), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst col_valid", 32'(col_valid), 32'd0);
        check("midrst wall_addr", 32'(wall_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < 14; k++) begin
                @(posedge clk);
                #1 if (col_valid) cnt++;
            end
            check("midrst no pulse", 32'(cnt), 32'd0);
        end
        scan("post-reset", vecs[1].pos, 4'b1111, 1'b0);

        // Randomized scans against the pixel model
        for (int n = 0; n < 40; n++) begin
            logic [7:0][39:0] w;
            int xs, ys;
            case ($urandom_range(0, 5))
                0:       xs = 0;
                1:       xs = SW - PW;
                default: xs = $urandom_range(0, SW - 1);
            endcase
            case ($urandom_range(0, 5))
                0:       ys = 0;
                1:       ys = SH - PH;
                default: ys = $urandom_range(0, SH - 1);
            endcase
            for (int k = 0; k < 8; k++) begin
                int x0, y0, x1, y1;
                x0 = xs + $urandom_range(0, 110) - 70;
                y0 = ys + $urandom_range(0, 110) - 70;
                x0 = (x0 < 0) ? 0 : x0;
                y0 = (y0 < 0) ? 0 : y0;
                x1 = x0 + $urandom_range(0, 70);
                y1 = y0 + $urandom_range(0, 70);
                x1 = (x1 > 1023) ? 1023 : x1;
                y1 = (y1 > 1023) ? 1023 : y1;
                if ($urandom_range(0, 7) == 0) w[k] = wl(x1 + 1, y0, x0, y1);
                else                           w[k] = wl(x0, y0, x1, y1);
            end
            load(w);
            scan($sformatf("rand%0d", n), pp(xs, ys), model(xs, ys, w), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
